debounce_pulse: RTL and testbench

//   Conditions one asynchronous, bouncy input (push-button or external event line) into a clean,

---
 rtl/debounce_pulse.sv | 160 ++++++++++++++++
 tb/tb_debounce_pulse.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Synchronises and debounces one bouncy input into a clean level and a one-cycle press strobe.
// Optional feature macro: LONG_PRESS_EN adds a long_press strobe after HOLD_CYCLES of sustained press.
module debounce_pulse #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        ACTIVE_LEVEL    = 1'b1,
    parameter int unsigned HOLD_CYCLES     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic pulse,
    output logic level,
    output logic busy
`ifdef LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic            SINGLE   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
            $error("debounce_pulse: illegal parameter value");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Input synchroniser; stage 0 captures raw_in normalised to 1 = pressed
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in ~^ ACTIVE_LEVEL};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Debounce FSM with registered strobe, level and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_in) begin
                        if (SINGLE) begin
                            state <= PRESSED;
                            cnt   <= '0;
                            pulse <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_in) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
                        busy  <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_in) begin
                        if (SINGLE) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                        end else begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_in) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned      HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold timer runs through release bounces and saturates, so it fires once per press
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        long_press <= 1'b1;
                    end
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// Randomised bench for debounce_pulse against a run-length reference model of the debounce rules.
module tb_debounce_pulse;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
    localparam int unsigned H = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic pulse;
    logic level;
    logic busy;
`ifdef LONG_PRESS_EN
    logic long_press;
`endif

    debounce_pulse #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LEVEL   (1'b1),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw_in(raw_in),
        .pulse (pulse),
        .level (level),
        .busy  (busy)
`ifdef LONG_PRESS_EN
        ,
        .long_press(long_press)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw history line, run length of samples disagreeing with the level
    logic hist [S];
    logic m_level, m_pulse, m_busy, m_lp;
    int   m_run, m_held;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input logic r_raw, input logic r_rst);
        logic s;
        if (r_rst) begin
            for (int i = 0; i < S; i++) hist[i] = 1'b0;
            m_level = 1'b0; m_pulse = 1'b0; m_busy = 1'b0; m_lp = 1'b0;
            m_run = 0; m_held = 0;
        end else begin
            s = hist[S-1];
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = r_raw;
            m_pulse = 1'b0;
            m_lp = 1'b0;
            if (m_level) begin
                m_held++;
                if (m_held == int'(H)) m_lp = 1'b1;
            end
            if (s != m_level) begin
                m_run++;
                if (m_run == int'(D)) begin
                    m_level = s;
                    m_run = 0;
                    if (s) begin
                        m_pulse = 1'b1;
                        m_held = 0;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_busy = (m_run != 0);
        end
    endtask

    task automatic step(input logic r_raw, input logic r_rst);
        raw_in = r_raw;
        rst = r_rst;
        @(posedge clk);
        model_edge(r_raw, r_rst);
        #1;
        check_eq("pulse", 32'(pulse), 32'(m_pulse));
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("busy", 32'(busy), 32'(m_busy));
`ifdef LONG_PRESS_EN
        check_eq("long_press", 32'(long_press), 32'(m_lp));
`endif
    endtask

    initial begin
        int lat, pcount, lp_idx, seg_len;
        logic v;

        // Reset state
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Clean press: latency and single-cycle strobe, then sustained hold
        lat = -1; pcount = 0; lp_idx = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            if (pulse === 1'b1) begin
                pcount++;
                if (lat < 0) lat = i;
            end
`ifdef LONG_PRESS_EN
            if (long_press === 1'b1 && lp_idx < 0) lp_idx = i;
`endif
        end
        check_eq("press_latency", 32'(lat), 32'(S + D - 1));
        check_eq("pulse_count_single", 32'(pcount), 32'd1);
`ifdef LONG_PRESS_EN
        check_eq("long_press_delay", 32'(lp_idx - lat), 32'(H));
`endif

        // Release bounce while pressed, then full release
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Short press rejected
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Reset in mid-qualification
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (pulse === 1'b1 && lat < 0) lat = i;
        end
        check_eq("latency_after_reset", 32'(lat), 32'(S + D - 1));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Twenty clean presses give twenty strobes
        pcount = 0;
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b0);
                if (pulse === 1'b1) pcount++;
            end
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        end
        check_eq("pulse_count_20", 32'(pcount), 32'd20);

        // Random bouncy segments with occasional resets
        for (int seg = 0; seg < 600; seg++) begin
            v = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: seg_len = $urandom_range(1, 3);
                1: seg_len = $urandom_range(3, 6);
                2: seg_len = $urandom_range(5, 12);
                default: seg_len = $urandom_range(10, 25);
            endcase
            for (int i = 0; i < seg_len; i++) begin
                step(v, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
